// File: rtl/dram_ctrl_arb.sv
// RAS/CAS DRAM controller shared by NCH requesters, with an internal
// CAS-before-RAS refresh timer and fixed-priority or round-robin arbitration.
module dram_ctrl_arb #(
  parameter int NCH         = 3,
  parameter int AW          = 23,
  parameter int ROW_BITS    = 12,
  parameter int COL_BITS    = 11,
  parameter int DRAM_AW     = 12,
  parameter int DW          = 32,
  parameter int T_RCD       = 2,
  parameter int T_CAS       = 3,
  parameter int T_RP        = 1,
  parameter int T_RAS_REF   = 5,
  parameter int REFR_PERIOD = 390,
  parameter int ARB_RR      = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NCH-1:0]      req,
  input  logic [NCH-1:0]      we,
  input  logic [NCH*AW-1:0]   addr,
  input  logic [NCH*DW-1:0]   wdata,
  output logic [DW-1:0]       rdata,
  output logic [NCH-1:0]      ack,
  output logic                busy,
  output logic                ref_overrun,
  input  logic [DW-1:0]       dram_dq,
  output logic [DW-1:0]       dram_di,
  output logic                dram_t,
  output logic [DRAM_AW-1:0]  dram_a,
  output logic                dram_we,
  output logic                dram_ras,
  output logic                dram_cas
);

  localparam int CW        = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int RW        = (REFR_PERIOD > 1) ? $clog2(REFR_PERIOD) : 1;
  localparam int T_ACC_END = 2 + T_RCD + T_CAS + T_RP;
  localparam int T_REF_END = 2 + T_RAS_REF + T_RP;
  localparam int T_MAX     = (T_ACC_END > T_REF_END) ? T_ACC_END : T_REF_END;
  localparam int CNTW      = $clog2(T_MAX + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_REF  = 2'd2;

  // Edge numbers (counted from the grant edge) at which each strobe moves
  localparam logic [CNTW-1:0] K_RAS  = CNTW'(1);
  localparam logic [CNTW-1:0] K_COL  = CNTW'(2);
  localparam logic [CNTW-1:0] K_CAS  = CNTW'(1 + T_RCD);
  localparam logic [CNTW-1:0] K_WEH  = CNTW'(T_RCD + T_CAS);
  localparam logic [CNTW-1:0] K_REL  = CNTW'(1 + T_RCD + T_CAS);
  localparam logic [CNTW-1:0] K_ACK  = CNTW'(1 + T_RCD + T_CAS + T_RP);
  localparam logic [CNTW-1:0] K_AEND = CNTW'(T_ACC_END);
  localparam logic [CNTW-1:0] K_RCAS = CNTW'(1);
  localparam logic [CNTW-1:0] K_RRAS = CNTW'(2);
  localparam logic [CNTW-1:0] K_RCH  = CNTW'(4);
  localparam logic [CNTW-1:0] K_RRH  = CNTW'(2 + T_RAS_REF);
  localparam logic [CNTW-1:0] K_REND = CNTW'(T_REF_END);

  typedef struct packed {
    logic [CW-1:0] ch;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_req_t;

  logic [NCH-1:0][AW-1:0] ch_addr;
  logic [NCH-1:0][DW-1:0] ch_wdata;
  logic [NCH-1:0]         ack_oh;
  logic [1:0]             state;
  logic [CNTW-1:0]        cnt, k;
  logic [RW-1:0]          tmr;
  logic                   tmr_exp, ref_pending, ref_again, ref_grant;
  logic [CW-1:0]          rr_ptr, gnt_ch;
  logic                   gnt_vld;
  acc_req_t               cur;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign ch_addr[i]  = addr[i*AW +: AW];
    assign ch_wdata[i] = wdata[i*DW +: DW];
    assign ack_oh[i]   = (cur.ch == CW'(i));
  end

  assign busy      = (state != S_IDLE);
  assign k         = cnt + 1'b1;
  assign tmr_exp   = (tmr == '0);
  assign ref_grant = (state == S_IDLE) && ref_pending;

  // Descending scan so the last hit is the first channel in search order;
  // fixed priority is round-robin with the start pinned at channel 0.
  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    idx     = 0;
    for (int j = NCH-1; j >= 0; j--) begin
      idx = (ARB_RR != 0) ? int'(rr_ptr) + j : j;
      if (idx >= NCH) idx = idx - NCH;
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_ch  = CW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) tmr <= RW'(REFR_PERIOD - 1);
    else if (tmr_exp) tmr <= RW'(REFR_PERIOD - 1);
    else tmr <= tmr - 1'b1;
  end

  // An expiry on the grant edge is remembered so the pending flag survives
  // the clear at RAS-fall; any other expiry while pending is an overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_pending <= 1'b0;
      ref_again   <= 1'b0;
      ref_overrun <= 1'b0;
    end else begin
      if (tmr_exp && ref_pending && !ref_grant) ref_overrun <= 1'b1;
      if (state == S_REF && k == K_RRAS) begin
        ref_pending <= ref_again | tmr_exp;
        ref_again   <= 1'b0;
      end else begin
        if (tmr_exp) ref_pending <= 1'b1;
        if (tmr_exp && ref_grant) ref_again <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      cur      <= '0;
      rr_ptr   <= '0;
      rdata    <= '0;
      ack      <= '0;
      dram_a   <= '0;
      dram_di  <= '0;
      dram_t   <= 1'b1;
      dram_we  <= 1'b1;
      dram_ras <= 1'b1;
      dram_cas <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          ack <= '0;
          cnt <= '0;
          if (ref_pending) begin
            state <= S_REF;
          end else if (gnt_vld) begin
            state     <= S_ACC;
            cur.ch    <= gnt_ch;
            cur.we    <= we[gnt_ch];
            cur.addr  <= ch_addr[gnt_ch];
            cur.wdata <= ch_wdata[gnt_ch];
            dram_a    <= DRAM_AW'(ch_addr[gnt_ch][COL_BITS +: ROW_BITS]);
            rr_ptr    <= (gnt_ch == CW'(NCH - 1)) ? '0 : gnt_ch + 1'b1;
          end
        end
        S_ACC: begin
          cnt <= k;
          if (k == K_RAS) dram_ras <= 1'b0;
          if (k == K_COL) begin
            dram_a <= DRAM_AW'(cur.addr[COL_BITS-1:0]);
            if (cur.we) begin
              dram_we <= 1'b0;
              dram_t  <= 1'b0;
              dram_di <= cur.wdata;
            end
          end
          if (k == K_CAS) dram_cas <= 1'b0;
          if (k == K_WEH && cur.we) dram_we <= 1'b1;
          if (k == K_REL) begin
            dram_ras <= 1'b1;
            dram_cas <= 1'b1;
            dram_a   <= '0;
            dram_t   <= 1'b1;
            dram_di  <= '0;
            if (!cur.we) rdata <= dram_dq;
          end
          if (k == K_ACK) ack <= ack_oh;
          if (k == K_AEND) begin
            ack   <= '0;
            state <= S_IDLE;
          end
        end
        S_REF: begin
          cnt <= k;
          if (k == K_RCAS) dram_cas <= 1'b0;
          if (k == K_RRAS) dram_ras <= 1'b0;
          if (k == K_RCH)  dram_cas <= 1'b1;
          if (k == K_RRH)  dram_ras <= 1'b1;
          if (k == K_REND) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
